// File: rtl/wb_store_queue.sv
// rtl/wb_store_queue.sv - writeback store queue draining 1..2 line-bounded beats per entry to the dcache
module wb_store_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ld,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_data,
  input  logic [1:0]  memsize,
  input  logic [6:0]  inst_ptcid,
  output logic        wbaq_full,
  output logic [4:0]  count,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [63:0] wr_data,
  output logic [3:0]  wr_len,
  output logic [6:0]  wr_ptcid,
  input  logic        wr_ack,
  input  logic [31:0] chk_addr,
  output logic        chk_conflict,
  output logic        ovf_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;

  logic [31:0] addr_q  [DEPTH];
  logic [63:0] data_q  [DEPTH];
  logic [1:0]  size_q  [DEPTH];
  logic [6:0]  ptcid_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [4:0]    count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          ovf_q, ovf_d;

  logic          enq;
  logic          retire;

  logic [31:0]   h_addr;
  logic [63:0]   h_data;
  logic [1:0]    h_size;
  logic [3:0]    h_nb;
  logic [3:0]    h_first_len;
  logic          h_split;

  logic [AW-1:0] rel;
  logic          conflict;

  // An entry crosses into the next 16-byte line when offset + size exceeds 16.
  function automatic logic is_split(input logic [3:0] off, input logic [1:0] sz);
    logic [4:0] nb;
    nb = 5'd1 << sz;
    return ({1'b0, off} + nb) > 5'd16;
  endfunction

  assign wbaq_full = (count_q == 5'(DEPTH));
  assign count     = count_q;
  assign ovf_err   = ovf_q;

  assign enq    = mem_ld && !wbaq_full;
  assign retire = wr_ack && ((state_q == S_BEAT2) || (state_q == S_BEAT1 && !h_split));

  assign h_addr      = addr_q[head_q];
  assign h_data      = data_q[head_q];
  assign h_size      = size_q[head_q];
  assign h_nb        = 4'd1 << h_size;
  assign h_first_len = ~h_addr[3:0] + 4'd1;
  assign h_split     = is_split(h_addr[3:0], h_size);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {4'd0, enq} - {4'd0, retire};
    ovf_d   = ovf_q || (mem_ld && wbaq_full);
    state_d = state_q;
    if (enq)    tail_d = tail_q + 1'b1;
    if (retire) head_d = head_q + 1'b1;
    case (state_q)
      S_IDLE:  if (count_q != 5'd0) state_d = S_BEAT1;
      S_BEAT1: if (wr_ack) begin
                 if (h_split)              state_d = S_BEAT2;
                 else if (count_q > 5'd1)  state_d = S_BEAT1;
                 else                      state_d = S_IDLE;
               end
      S_BEAT2: if (wr_ack) state_d = (count_q > 5'd1) ? S_BEAT1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage needs no reset: only slots inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= mem_addr;
      data_q[tail_q]  <= mem_data;
      size_q[tail_q]  <= memsize;
      ptcid_q[tail_q] <= inst_ptcid;
    end
  end

  always_comb begin
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_len   = '0;
    wr_ptcid = '0;
    case (state_q)
      S_BEAT1: begin
        wr_req   = 1'b1;
        wr_addr  = h_addr;
        wr_data  = h_data;
        wr_len   = h_split ? h_first_len : h_nb;
        wr_ptcid = ptcid_q[head_q];
      end
      S_BEAT2: begin
        wr_req   = 1'b1;
        wr_addr  = {h_addr[31:4] + 28'd1, 4'h0};
        wr_data  = h_data >> {h_first_len[2:0], 3'b000};
        wr_len   = h_nb - h_first_len;
        wr_ptcid = ptcid_q[head_q];
      end
      default: ;
    endcase
  end

  // Line index arithmetic is 28-bit so the top line wraps to line 0.
  always_comb begin
    conflict = 1'b0;
    rel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - head_q;
      if (({{(5-AW){1'b0}}, rel} < count_q) &&
          ((addr_q[i][31:4] == chk_addr[31:4]) ||
           (is_split(addr_q[i][3:0], size_q[i]) &&
            (addr_q[i][31:4] + 28'd1 == chk_addr[31:4]))))
        conflict = 1'b1;
    end
  end

  assign chk_conflict = conflict;

endmodule

// File: tb/tb_wb_store_queue.sv
// tb/tb_wb_store_queue.sv - directed self-checking bench for wb_store_queue
module tb_wb_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ld;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [1:0]  memsize;
  logic [6:0]  inst_ptcid;
  logic        wbaq_full;
  logic [4:0]  count;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  wr_len;
  logic [6:0]  wr_ptcid;
  logic        wr_ack;
  logic [31:0] chk_addr;
  logic        chk_conflict;
  logic        ovf_err;

  int n_cmp = 0;
  int n_bad = 0;

  wb_store_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mem_ld(mem_ld), .mem_addr(mem_addr), .mem_data(mem_data),
    .memsize(memsize), .inst_ptcid(inst_ptcid), .wbaq_full(wbaq_full), .count(count),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len),
    .wr_ptcid(wr_ptcid), .wr_ack(wr_ack), .chk_addr(chk_addr),
    .chk_conflict(chk_conflict), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz, input logic [6:0] tag);
    mem_ld     = 1'b1;
    mem_addr   = a;
    mem_data   = d;
    memsize    = sz;
    inst_ptcid = tag;
  endtask

  initial begin
    rst = 1'b0; mem_ld = 1'b0; mem_addr = '0; mem_data = '0; memsize = '0;
    inst_ptcid = '0; wr_ack = 1'b0; chk_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_req", wr_req, 0);
    check("rst_count", count, 0);
    check("rst_full", wbaq_full, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_conflict", chk_conflict, 0);
    check("rst_wr_addr", wr_addr, 0);
    rst = 1'b1;

    // ack while idle is ignored; then single aligned 8B store with ack tied high
    wr_ack = 1'b1;
    step();
    check("idle_ack_count", count, 0);
    check("idle_ack_req", wr_req, 0);
    push(32'h1000, 64'h1122334455667788, 2'b11, 7'd1);
    step();
    mem_ld = 1'b0;
    check("s1_count1", count, 1);
    step();
    check("s1_req", wr_req, 1);
    check("s1_addr", wr_addr, 32'h1000);
    check("s1_len", wr_len, 8);
    check("s1_data", wr_data, 64'h1122334455667788);
    check("s1_ptcid", wr_ptcid, 1);
    step();
    check("s1_empty", count, 0);
    check("s1_req_done", wr_req, 0);
    wr_ack = 1'b0;

    // split 8B store at 0x100C, ack delayed
    push(32'h100C, 64'h8877665544332211, 2'b11, 7'd2);
    step();
    mem_ld = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      check("sp_b1_req", wr_req, 1);
      check("sp_b1_addr", wr_addr, 32'h100C);
      check("sp_b1_len", wr_len, 4);
      check("sp_b1_data", wr_data[31:0], 32'h44332211);
      if (c < 2) step();
    end
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    check("sp_b2_req", wr_req, 1);
    check("sp_b2_addr", wr_addr, 32'h1010);
    check("sp_b2_len", wr_len, 4);
    check("sp_b2_data", wr_data[31:0], 32'h88776655);
    check("sp_b2_count", count, 1);
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    check("sp_empty", count, 0);
    check("sp_req_done", wr_req, 0);

    // fill to full, overflow, then retire while an enqueue arrives at full
    for (int i = 0; i < 8; i++) begin
      push(32'h4000 + 32'(i) * 32'h10, 64'(i), 2'b11, 7'(i));
      step();
    end
    check("fill_count", count, 8);
    check("fill_full", wbaq_full, 1);
    check("fill_ovf0", ovf_err, 0);
    push(32'h9000, 64'h99, 2'b11, 7'd99);
    step();
    check("ovf_set", ovf_err, 1);
    check("ovf_count", count, 8);
    check("head0_addr", wr_addr, 32'h4000);
    push(32'hDEAD0, 64'hDEAD, 2'b11, 7'd77);
    wr_ack = 1'b1;
    step();
    mem_ld = 1'b0;
    check("full_ack_count", count, 7);
    check("full_ack_notfull", wbaq_full, 0);
    check("full_ack_ovf", ovf_err, 1);
    for (int i = 1; i < 8; i++) begin
      check("order_req", wr_req, 1);
      check("order_addr", wr_addr, 32'h4000 + 32'(i) * 32'h10);
      check("order_ptcid", wr_ptcid, 64'(i));
      step();
    end
    wr_ack = 1'b0;
    check("drain_count", count, 0);
    check("drain_req", wr_req, 0);

    // split 4B store at 0x2FFE: conflict on both lines
    push(32'h2FFE, 64'hAABBCCDD, 2'b10, 7'd5);
    step();
    mem_ld = 1'b0;
    chk_addr = 32'h2FF0; #1;
    check("cf_2ff0", chk_conflict, 1);
    chk_addr = 32'h3004; #1;
    check("cf_3004", chk_conflict, 1);
    chk_addr = 32'h3010; #1;
    check("cf_3010", chk_conflict, 0);
    chk_addr = 32'h2FF0;
    step();
    check("c_b1_addr", wr_addr, 32'h2FFE);
    check("c_b1_len", wr_len, 2);
    check("c_b1_ptcid", wr_ptcid, 5);
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    check("c_b2_addr", wr_addr, 32'h3000);
    check("c_b2_len", wr_len, 2);
    check("c_b2_data", wr_data[15:0], 16'hAABB);
    check("c_b2_conflict", chk_conflict, 1);

    // reset in the middle of BEAT2
    rst = 1'b0;
    #1;
    check("mr_req", wr_req, 0);
    check("mr_count", count, 0);
    check("mr_conflict", chk_conflict, 0);
    check("mr_ovf", ovf_err, 0);
    check("mr_len", wr_len, 0);
    check("mr_ptcid", wr_ptcid, 0);
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_idle", wr_req, 0);
    end

    // split across the top line, wrapping to line 0
    push(32'hFFFFFFFC, 64'h0807060504030201, 2'b11, 7'd9);
    step();
    mem_ld = 1'b0;
    chk_addr = 32'h00000004; #1;
    check("wrap_conflict", chk_conflict, 1);
    step();
    check("wrap_b1_len", wr_len, 4);
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    check("wrap_b2_addr", wr_addr, 32'h0);
    check("wrap_b2_len", wr_len, 4);
    check("wrap_b2_data", wr_data[31:0], 32'h08070605);
    wr_ack = 1'b1;
    step();
    check("wrap_empty", count, 0);

    // store after reset drains normally
    push(32'h5008, 64'h5A, 2'b00, 7'd3);
    step();
    mem_ld = 1'b0;
    check("pr_count", count, 1);
    step();
    check("pr_addr", wr_addr, 32'h5008);
    check("pr_len", wr_len, 1);
    check("pr_data", wr_data[7:0], 8'h5A);
    step();
    check("pr_empty", count, 0);
    check("pr_req_done", wr_req, 0);
    wr_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_store_queue.md
WB_STORE_QUEUE -- requirements
Module: wb_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queued store entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_ld  input  1  enqueue strobe from writeback: one store this cycle.
REQ-005 SHALL have port mem_addr  input  32  store byte address.
REQ-006 SHALL have port mem_data  input  64  store data, little-endian, byte 0 in [7:0].
REQ-007 SHALL have port memsize  input  2  size code: 00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 SHALL have port inst_ptcid  input  7  tag of the storing instruction.
REQ-009 SHALL have port wbaq_full  output  1  queue full; writeback stalls on it.
REQ-010 SHALL have port count  output  5  number of occupied entries.
REQ-011 SHALL have port wr_req  output  1  write beat valid toward the dcache.
REQ-012 SHALL have port wr_addr  output  32  beat byte address.
REQ-013 SHALL have port wr_data  output  64  beat data, byte 0 at [7:0].
REQ-014 SHALL have port wr_len  output  4  beat byte count, 1..8.
REQ-015 SHALL have port wr_ptcid  output  7  tag of the head entry.
REQ-016 SHALL have port wr_ack  input  1  dcache accepts the current beat this cycle.
REQ-017 SHALL have port chk_addr  input  32  load address for conflict check.
REQ-018 SHALL have port chk_conflict  output  1  combinational: a pending store touches the line of chk_addr.
REQ-019 SHALL have port ovf_err  output  1  sticky: an enqueue arrived while full.

Function
REQ-020 SHALL be a circular FIFO of DEPTH entries {addr, data, size, ptcid} with head/tail pointers that wrap modulo DEPTH.
REQ-021 SHALL enqueue at tail on a rising edge when mem_ld=1 and wbaq_full=0.
REQ-022 SHALL drive wbaq_full = (count==DEPTH) from registered state only, with no combinational path from mem_ld or wr_ack.
REQ-023 SHALL drop an enqueue attempted while wbaq_full=1, leave queue state unchanged, and set ovf_err until reset.
REQ-024 SHALL update count by +1, -1 or 0 on simultaneous enqueue and entry retirement in the same cycle; pointers advance independently.
REQ-025 SHALL implement drain FSM IDLE, BEAT1, BEAT2: IDLE->BEAT1 when count>0.
REQ-026 SHALL compute nbytes = 1<<memsize and off = addr[3:0]; an entry is split when off+nbytes>16.
REQ-027 SHALL in BEAT1 drive wr_req=1, wr_addr=addr, wr_len = split ? 16-off : nbytes, wr_data=data.
REQ-028 SHALL in BEAT2 drive wr_req=1, wr_addr={addr[31:4]+1,4'h0}, wr_len = nbytes-(16-off), wr_data = data >> 8*(16-off).
REQ-029 SHALL hold all wr_* outputs stable while wr_req=1 and wr_ack=0.
REQ-030 SHALL on wr_ack in BEAT1 go to BEAT2 if split, else retire the head entry and go to BEAT1 if count>1, else to IDLE.
REQ-031 SHALL on wr_ack in BEAT2 retire the head entry and go to BEAT1 if count>1, else to IDLE.
REQ-032 SHALL take the head entry and a new enqueue as two separate entries when they arrive in the same cycle, including when count==1.
REQ-033 SHALL ignore wr_ack while wr_req=0.
REQ-034 SHALL assert chk_conflict when any occupied entry, including one mid-drain, has addr[31:4]==chk_addr[31:4], or is split and addr[31:4]+1==chk_addr[31:4].
REQ-035 SHALL count line index wrap (addr[31:4]=0xFFFFFFF -> 0x0000000) as modular for split and conflict purposes.
REQ-036 SHALL drive wr_ptcid = head ptcid in BEAT1 and BEAT2.

Reset
REQ-037 SHALL on rst=0, asynchronously and regardless of FSM state, clear head, tail and count to 0 and force FSM to IDLE.
REQ-038 SHALL during reset drive wr_req=0, wbaq_full=0, ovf_err=0, chk_conflict=0, count=0, and wr_addr/wr_data/wr_len/wr_ptcid=0.
REQ-039 SHALL discard queued stores on reset mid-drain and issue no further beat until a new enqueue.

Verification
REQ-040 SHALL be verified by: single store addr=0x1000, size 11, data=0x1122334455667788, wr_ack tied 1 -> one beat, wr_addr=0x1000, wr_len=8, queue empty 2 cycles after enqueue.
REQ-041 SHALL be verified by: store addr=0x100C, size 11, data=0x8877665544332211, ack after 3 cycles -> BEAT1 addr=0x100C len=4 data[31:0]=0x44332211 held stable; BEAT2 addr=0x1010 len=4 data[31:0]=0x88776655.
REQ-042 SHALL be verified by: 8 stores with wr_ack=0 -> wbaq_full=1, count=8; ninth mem_ld -> ovf_err=1, count stays 8; then ack all -> 8 beats in enqueue order.
REQ-043 SHALL be verified by: count=8 with wr_ack=1 on the final beat and mem_ld=1 in the same cycle -> enqueue dropped (full registered), ovf_err=1, count=7.
REQ-044 SHALL be verified by: pending split store at 0x2FFE, size 10 -> chk_addr 0x2FF0 and 0x3004 give conflict=1, 0x3010 gives 0.
REQ-045 SHALL be verified by: rst=0 asserted mid-BEAT2 -> wr_req=0 immediately, count=0, then after release a new store drains normally.
